// File: rtl/usb_tx_arb_pkg.sv
// Shared definitions for the USB transmit wire arbiter.
// Holds the arbiter state encoding and the index-width helper.
package usb_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GRANT = 2'd2
  } arbState_e;

  // Bits needed to index n items, never less than one.
  function automatic int idxWidth(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/usb_arb_pick.sv
// Combinational winner search for the transmit arbiter.
// Ports:
//   req, mask  - per-requester request and exclusion mask
//   startIdx   - first index searched in round-robin mode (ignored in fixed mode)
//   found      - at least one eligible requester exists
//   winner     - index of the first eligible requester in search order
module usb_arb_pick
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int RR_EN   = 1,
  parameter int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   startIdx,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [NUM_REQ-1:0]   eligible_s;
  logic [IDX_W-1:0]     start_s;
  logic [2*NUM_REQ-1:0] doubled_s;
  logic [NUM_REQ-1:0]   rotated_s;

  // Rotate the eligible vector so bit 0 is the first index searched, then take the lowest set bit.
  always_comb begin
    int sum;
    sum        = 0;
    found      = 1'b0;
    winner     = {IDX_W{1'b0}};
    eligible_s = req & ~mask;
    start_s    = (RR_EN != 0) ? startIdx : {IDX_W{1'b0}};
    // Doubling the vector makes the shifted window wrap around the top index.
    doubled_s  = {eligible_s, eligible_s} >> start_s;
    rotated_s  = doubled_s[NUM_REQ-1:0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated_s[k]) begin
        sum = int'(start_s) + k;
        if (sum >= NUM_REQ) begin
          sum = sum - NUM_REQ;
        end else begin
          sum = sum + 0;
        end
        found  = 1'b1;
        winner = IDX_W'(sum);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/usb_tx_wire_arb_n.sv
// N-way arbiter sharing one USB transmit wire between several requesters.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req, wen, ctrl, fs_rate, data - per-requester request and wire fields
//   USBWireRdyIn    - ready from the line driver, passed straight back out
//   gnt             - registered one-hot grant
//   TxBits, TxCtl, TxFSRate, USBWireWEn - wire fields of the current owner
//   USBWireRdyOut   - copy of USBWireRdyIn
//   owner, busy     - current/last owner index, grant active
//   hold_expired    - one-cycle pulse when a grant is cut off at MAX_HOLD
module usb_tx_wire_arb_n
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 2,
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            wen,
  input  logic [NUM_REQ-1:0]            ctrl,
  input  logic [NUM_REQ-1:0]            fs_rate,
  input  logic [NUM_REQ*DATA_W-1:0]     data,
  input  logic                          USBWireRdyIn,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_W-1:0]             TxBits,
  output logic                          TxCtl,
  output logic                          TxFSRate,
  output logic                          USBWireWEn,
  output logic                          USBWireRdyOut,
  output logic [idxWidth(NUM_REQ)-1:0]  owner,
  output logic                          busy,
  output logic                          hold_expired
);

  localparam int IDX_W     = idxWidth(NUM_REQ);
  localparam int HOLD_W    = idxWidth(MAX_HOLD);
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arbState_e          state_r, stateNext_s;
  logic [NUM_REQ-1:0] gnt_r, gntNext_s;
  logic [NUM_REQ-1:0] mask_r, maskNext_s;
  logic [IDX_W-1:0]   owner_r, ownerNext_s;
  logic [IDX_W-1:0]   rrStart_r, rrStartNext_s;
  logic [HOLD_W-1:0]  holdCnt_r, holdCntNext_s;
  logic               busy_r, busyNext_s;
  logic               holdExpired_r, holdExpiredNext_s;
  logic               pickFound_s;
  logic [IDX_W-1:0]   pickWinner_s;
  logic               ownerReq_s;
  logic [DATA_W-1:0]  txBits_s;
  logic               txCtl_s, txFs_s, wenSel_s;

  usb_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .RR_EN   (RR_EN),
    .IDX_W   (IDX_W)
  ) uPick (
    .req      (req),
    .mask     (mask_r),
    .startIdx (rrStart_r),
    .found    (pickFound_s),
    .winner   (pickWinner_s)
  );

  assign ownerReq_s = req[owner_r];

  // Next-state and next-output logic for the INIT/IDLE/GRANT controller.
  always_comb begin
    stateNext_s       = state_r;
    gntNext_s         = gnt_r;
    ownerNext_s       = owner_r;
    rrStartNext_s     = rrStart_r;
    holdCntNext_s     = holdCnt_r;
    busyNext_s        = busy_r;
    holdExpiredNext_s = 1'b0;
    // A mask bit lives only while its request stays high.
    maskNext_s        = mask_r & req;
    case (state_r)
      ST_INIT: begin
        stateNext_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (pickFound_s) begin
          stateNext_s               = ST_GRANT;
          gntNext_s                 = {NUM_REQ{1'b0}};
          gntNext_s[pickWinner_s]   = 1'b1;
          ownerNext_s               = pickWinner_s;
          busyNext_s                = 1'b1;
          holdCntNext_s             = {HOLD_W{1'b0}};
          if (pickWinner_s == IDX_W'(NUM_REQ - 1)) begin
            rrStartNext_s = {IDX_W{1'b0}};
          end else begin
            rrStartNext_s = pickWinner_s + IDX_W'(1'b1);
          end
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!ownerReq_s) begin
          stateNext_s = ST_IDLE;
          gntNext_s   = {NUM_REQ{1'b0}};
          busyNext_s  = 1'b0;
        end else if ((MAX_HOLD > 0) && (holdCnt_r == HOLD_W'(HOLD_LAST))) begin
          // Forced release: the owner is masked until it drops its request.
          stateNext_s         = ST_IDLE;
          gntNext_s           = {NUM_REQ{1'b0}};
          busyNext_s          = 1'b0;
          holdExpiredNext_s   = 1'b1;
          maskNext_s[owner_r] = 1'b1;
        end else begin
          holdCntNext_s = holdCnt_r + HOLD_W'(1'b1);
        end
      end
      default: begin
        stateNext_s = ST_INIT;
        gntNext_s   = {NUM_REQ{1'b0}};
        busyNext_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_INIT;
      gnt_r         <= {NUM_REQ{1'b0}};
      mask_r        <= {NUM_REQ{1'b0}};
      owner_r       <= {IDX_W{1'b0}};
      rrStart_r     <= {IDX_W{1'b0}};
      holdCnt_r     <= {HOLD_W{1'b0}};
      busy_r        <= 1'b0;
      holdExpired_r <= 1'b0;
    end else begin
      state_r       <= stateNext_s;
      gnt_r         <= gntNext_s;
      mask_r        <= maskNext_s;
      owner_r       <= ownerNext_s;
      rrStart_r     <= rrStartNext_s;
      holdCnt_r     <= holdCntNext_s;
      busy_r        <= busyNext_s;
      holdExpired_r <= holdExpiredNext_s;
    end
  end

  // AND-OR mux of the owner's wire fields; the owner index is kept while idle.
  always_comb begin
    txBits_s = {DATA_W{1'b0}};
    txCtl_s  = 1'b0;
    txFs_s   = 1'b0;
    wenSel_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      txBits_s = txBits_s | (data[i*DATA_W +: DATA_W] & {DATA_W{owner_r == IDX_W'(i)}});
      txCtl_s  = txCtl_s  | (ctrl[i]    & (owner_r == IDX_W'(i)));
      txFs_s   = txFs_s   | (fs_rate[i] & (owner_r == IDX_W'(i)));
      wenSel_s = wenSel_s | (wen[i]     & (owner_r == IDX_W'(i)));
    end
  end

  assign gnt           = gnt_r;
  assign owner         = owner_r;
  assign busy          = busy_r;
  assign hold_expired  = holdExpired_r;
  assign TxBits        = txBits_s;
  assign TxCtl         = txCtl_s;
  assign TxFSRate      = txFs_s;
  assign USBWireWEn    = busy_r & wenSel_s;
  assign USBWireRdyOut = USBWireRdyIn;

endmodule

// File: tb/tb_usb_tx_wire_arb_n.sv
// Scoreboard bench for usb_tx_wire_arb_n: dutA is round-robin with MAX_HOLD=4,
// dutB is fixed priority with unlimited hold.
module tb_usb_tx_wire_arb_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] reqA, reqB, wen, ctrl, fsRate;
  logic [7:0] data;
  logic       rdy;

  logic [3:0] gntA, gntB;
  logic [1:0] bitsA, bitsB, ownerA, ownerB;
  logic       ctlA, ctlB, fsA, fsB, wenA, wenB, rdyA, rdyB;
  logic       busyA, busyB, hexpA, hexpB;

  always #5 clk = ~clk;

  usb_tx_wire_arb_n #(.NUM_REQ(4), .DATA_W(2), .RR_EN(1), .MAX_HOLD(4)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .wen(wen), .ctrl(ctrl), .fs_rate(fsRate),
    .data(data), .USBWireRdyIn(rdy), .gnt(gntA), .TxBits(bitsA), .TxCtl(ctlA),
    .TxFSRate(fsA), .USBWireWEn(wenA), .USBWireRdyOut(rdyA), .owner(ownerA),
    .busy(busyA), .hold_expired(hexpA)
  );

  usb_tx_wire_arb_n #(.NUM_REQ(4), .DATA_W(2), .RR_EN(0), .MAX_HOLD(0)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .wen(wen), .ctrl(ctrl), .fs_rate(fsRate),
    .data(data), .USBWireRdyIn(rdy), .gnt(gntB), .TxBits(bitsB), .TxCtl(ctlB),
    .TxFSRate(fsB), .USBWireWEn(wenB), .USBWireRdyOut(rdyB), .owner(ownerB),
    .busy(busyB), .hold_expired(hexpB)
  );

  typedef struct {
    int         cyc;
    int         tag;
    bit         useB;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       hexp;
    logic       wenOut;
    logic [1:0] bits;
    logic       ctl;
    logic       fs;
    logic       rdyOut;
  } exp_t;

  exp_t       q[$];
  int         cyc  = 0;
  int         nVec = 0;
  int         nMis = 0;
  // Hand constants matching data=8'b00_11_10_01, ctrl=4'b0101, fsRate=4'b0011.
  logic [1:0] dataTbl [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic       ctrlTbl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       fsTbl   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [3:0] W = 4'b1011;

  // Cycle count used to align expectations with the edge they belong to.
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one input vector n times; each application expects the given state after the next edge.
  task automatic step(input int n, input int tag, input bit useB, input bit rstV,
                      input logic [3:0] reqV, input logic [3:0] wenV,
                      input logic [3:0] eGnt, input logic [1:0] eOwner,
                      input bit eBusy, input bit eHexp);
    exp_t e;
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      rst = rstV;
      if (useB) begin
        reqB = reqV; reqA = 4'b0000;
      end else begin
        reqA = reqV; reqB = 4'b0000;
      end
      wen      = wenV;
      rdy      = ~rdy;
      e.cyc    = cyc + 1;
      e.tag    = tag;
      e.useB   = useB;
      e.gnt    = eGnt;
      e.owner  = eOwner;
      e.busy   = eBusy;
      e.hexp   = eHexp;
      e.wenOut = eBusy & wenV[eOwner];
      e.bits   = dataTbl[eOwner];
      e.ctl    = ctrlTbl[eOwner];
      e.fs     = fsTbl[eOwner];
      e.rdyOut = rdy;
      q.push_back(e);
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares it with the addressed DUT.
  initial begin
    exp_t       e;
    logic [3:0] aGnt;
    logic [1:0] aOwner, aBits;
    logic       aBusy, aHexp, aWen, aCtl, aFs, aRdy;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.useB) begin
          aGnt = gntB; aOwner = ownerB; aBusy = busyB; aHexp = hexpB;
          aWen = wenB; aBits = bitsB; aCtl = ctlB; aFs = fsB; aRdy = rdyB;
        end else begin
          aGnt = gntA; aOwner = ownerA; aBusy = busyA; aHexp = hexpA;
          aWen = wenA; aBits = bitsA; aCtl = ctlA; aFs = fsA; aRdy = rdyA;
        end
        nVec++;
        if (aGnt !== e.gnt || aOwner !== e.owner || aBusy !== e.busy || aHexp !== e.hexp ||
            aWen !== e.wenOut || aBits !== e.bits || aCtl !== e.ctl || aFs !== e.fs ||
            aRdy !== e.rdyOut) begin
          nMis++;
          $display("FAIL t%0d%s cyc=%0d actual gnt=%b owner=%0d busy=%b hexp=%b wen=%b bits=%b ctl=%b fs=%b rdy=%b required gnt=%b owner=%0d busy=%b hexp=%b wen=%b bits=%b ctl=%b fs=%b rdy=%b",
                   e.tag, e.useB ? "B" : "A", e.cyc, aGnt, aOwner, aBusy, aHexp, aWen, aBits,
                   aCtl, aFs, aRdy, e.gnt, e.owner, e.busy, e.hexp, e.wenOut, e.bits, e.ctl,
                   e.fs, e.rdyOut);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    reqA   = 4'b0000;
    reqB   = 4'b0000;
    wen    = W;
    ctrl   = 4'b0101;
    fsRate = 4'b0011;
    data   = 8'b00_11_10_01;
    rdy    = 1'b0;

    // t1 (fixed): reset, INIT, grant two cycles after release, wen tracking, drop.
    step(2, 1, 1'b1, 1'b1, 4'b0000, W,       4'b0000, 2'd0, 1'b0, 1'b0);
    step(1, 1, 1'b1, 1'b0, 4'b0001, W,       4'b0000, 2'd0, 1'b0, 1'b0);
    step(2, 1, 1'b1, 1'b0, 4'b0001, W,       4'b0001, 2'd0, 1'b1, 1'b0);
    step(1, 1, 1'b1, 1'b0, 4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1, 1, 1'b1, 1'b0, 4'b0001, W,       4'b0001, 2'd0, 1'b1, 1'b0);
    step(2, 1, 1'b1, 1'b0, 4'b0000, W,       4'b0000, 2'd0, 1'b0, 1'b0);

    // t2 (fixed): req 1010, owner 1 releases and re-requests; 3 never wins.
    step(2, 2, 1'b1, 1'b0, 4'b1010, W, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1, 2, 1'b1, 1'b0, 4'b1000, W, 4'b0000, 2'd1, 1'b0, 1'b0);
    step(1, 2, 1'b1, 1'b0, 4'b1010, W, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1, 2, 1'b1, 1'b0, 4'b1000, W, 4'b0000, 2'd1, 1'b0, 1'b0);
    step(2, 2, 1'b1, 1'b0, 4'b1010, W, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(2, 2, 1'b1, 1'b0, 4'b0000, W, 4'b0000, 2'd1, 1'b0, 1'b0);

    // t6 (fixed): single-cycle request pulse in IDLE is granted, then released.
    step(1, 6, 1'b1, 1'b0, 4'b0100, W, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1, 6, 1'b1, 1'b0, 4'b0000, W, 4'b0000, 2'd2, 1'b0, 1'b0);

    // t3 (round-robin): all request, each grant lasts 3 cycles -> 0,1,2,3,0.
    step(1, 3, 1'b0, 1'b1, 4'b0000, W, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1, 3, 1'b0, 1'b0, 4'b1111, W, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0, 4'b1111, W, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1, 3, 1'b0, 1'b0, 4'b1110, W, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0, 4'b1111, W, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1, 3, 1'b0, 1'b0, 4'b1101, W, 4'b0000, 2'd1, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0, 4'b1111, W, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1, 3, 1'b0, 1'b0, 4'b1011, W, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0, 4'b1111, W, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1, 3, 1'b0, 1'b0, 4'b0111, W, 4'b0000, 2'd3, 1'b0, 1'b0);
    step(2, 3, 1'b0, 1'b0, 4'b1111, W, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1, 3, 1'b0, 1'b0, 4'b1110, W, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1, 3, 1'b0, 1'b0, 4'b0000, W, 4'b0000, 2'd0, 1'b0, 1'b0);

    // t4 (MAX_HOLD=4): req[2] held 10 cycles -> 4 grant cycles, one pulse, masked until it drops.
    step(4, 4, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1, 4, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1);
    step(5, 4, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(1, 4, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(1, 4, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1, 4, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);

    // t5: reset in the 2nd grant cycle of requester 1; INIT, IDLE, RR restarts at 0.
    step(2, 5, 1'b0, 1'b0, 4'b0010, W, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1, 5, 1'b0, 1'b1, 4'b0010, W, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1, 5, 1'b0, 1'b0, 4'b1001, W, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1, 5, 1'b0, 1'b0, 4'b1001, W, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1, 5, 1'b0, 1'b0, 4'b0000, W, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Bounded drain of the scoreboard.
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      $display("FAIL drain actual pending=%0d required pending=0", q.size());
      nMis++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
